stage_mixer: RTL

STAGE_MIXER -- requirements
Module: stage_mixer

---
 rtl/stage_mixer.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/stage_mixer.sv
// stage_mixer: mixes the carrier outputs of one voice frame into a single
// audio sample and writes every operator result back to the modulator.
//
// Pipeline (one operator result per cycle, no upstream stall):
//   cycle 1  scale      : carrier output >>> log2-ish(NumCarriers), else 0
//   cycle 2  accumulate : ID 0 loads, other IDs add, last ID flags frame end
//   cycle 3  finalize   : accumulator >>> MIX_SHIFT, saturate, load o_Sample
//
// Ports
//   i_Clock, i_Reset_n        clock, async active-low reset
//   i_Valid                   operator result present
//   i_VoiceOperator           operator ID (0 .. NUM_VOICE_OPERATORS-1)
//   i_AlgorithmWord           IsACarrier / NumCarriers of the operator
//   i_OperatorOutput          signed 16-bit operator output
//   o_OperatorWritebackValid  registered copy of i_Valid
//   o_OperatorWritebackID     registered copy of i_VoiceOperator
//   o_OperatorWritebackValue  registered copy of i_OperatorOutput
//   o_Sample, o_SampleValid   mixed sample and its valid flag
//   i_SampleReady             consumer accepts o_Sample
//   o_SampleOverrun           sticky: a sample was overwritten unconsumed

`ifndef NUM_VOICE_OPERATORS
`define NUM_VOICE_OPERATORS 8
`endif

package stage_mixer_pkg;
  localparam int unsigned VOICE_OP_W = $clog2(`NUM_VOICE_OPERATORS);

  typedef logic [VOICE_OP_W-1:0] VoiceOperatorID_t;

  typedef struct packed {
    logic       IsACarrier;
    logic [2:0] NumCarriers;
  } AlgorithmWord_t;
endpackage

module stage_mixer
  import stage_mixer_pkg::*;
#(
  parameter int ACC_WIDTH = 24,
  parameter int MIX_SHIFT = 3
) (
  input  logic                i_Clock,
  input  logic                i_Reset_n,
  input  logic                i_Valid,
  input  VoiceOperatorID_t    i_VoiceOperator,
  input  AlgorithmWord_t      i_AlgorithmWord,
  input  logic signed [15:0]  i_OperatorOutput,
  output logic                o_OperatorWritebackValid,
  output VoiceOperatorID_t    o_OperatorWritebackID,
  output logic signed [15:0]  o_OperatorWritebackValue,
  output logic signed [15:0]  o_Sample,
  output logic                o_SampleValid,
  input  logic                i_SampleReady,
  output logic                o_SampleOverrun
);

  localparam VoiceOperatorID_t LAST_ID = VoiceOperatorID_t'(`NUM_VOICE_OPERATORS - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_HI = ACC_WIDTH'(32767);
  localparam logic signed [ACC_WIDTH-1:0] SAT_LO = ACC_WIDTH'(-32768);

  // writeback registers
  logic                wb_valid_q, wb_valid_d;
  VoiceOperatorID_t    wb_id_q, wb_id_d;
  logic signed [15:0]  wb_value_q, wb_value_d;

  // scale stage
  logic                s1_valid_q, s1_valid_d;
  VoiceOperatorID_t    s1_id_q, s1_id_d;
  logic signed [15:0]  s1_term_q, s1_term_d;
  logic [1:0]          carrier_shift;

  // accumulate stage
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic signed [ACC_WIDTH-1:0] term_ext;
  logic                        armed_q, armed_d;
  logic                        done_q, done_d;

  // finalize stage
  logic signed [ACC_WIDTH-1:0] acc_shifted;
  logic signed [15:0]          sat_sample;
  logic signed [15:0]          sample_q, sample_d;
  logic                        sample_valid_q, sample_valid_d;
  logic                        overrun_q, overrun_d;

  always_comb begin
    wb_valid_d = i_Valid;
    wb_id_d    = i_VoiceOperator;
    wb_value_d = i_OperatorOutput;
  end

  // Carriers are pre-scaled so that the carrier sum stays roughly in range
  // regardless of how many carriers the algorithm has.
  always_comb begin
    case (i_AlgorithmWord.NumCarriers)
      3'd0, 3'd1: carrier_shift = 2'd0;
      3'd2:       carrier_shift = 2'd1;
      3'd3, 3'd4: carrier_shift = 2'd2;
      default:    carrier_shift = 2'd3;
    endcase

    s1_valid_d = i_Valid;
    s1_id_d    = i_VoiceOperator;
    s1_term_d  = '0;
    if (i_Valid && i_AlgorithmWord.IsACarrier) begin
      s1_term_d = i_OperatorOutput >>> carrier_shift;
    end
  end

  // armed_q blocks a frame end that was not preceded by an ID 0 since reset,
  // so a frame cut in half by reset never produces a sample.
  always_comb begin
    term_ext = {{(ACC_WIDTH-16){s1_term_q[15]}}, s1_term_q};
    acc_d    = acc_q;
    armed_d  = armed_q;
    done_d   = 1'b0;
    if (s1_valid_q) begin
      if (s1_id_q == '0) begin
        acc_d   = term_ext;
        armed_d = 1'b1;
      end else begin
        acc_d = acc_q + term_ext;
      end
      if ((s1_id_q == LAST_ID) && (armed_q || (s1_id_q == '0))) begin
        done_d = 1'b1;
      end
    end
  end

  always_comb begin
    acc_shifted = acc_q >>> MIX_SHIFT;
    if (acc_shifted > SAT_HI) begin
      sat_sample = 16'sh7FFF;
    end else if (acc_shifted < SAT_LO) begin
      sat_sample = 16'sh8000;
    end else begin
      sat_sample = acc_shifted[15:0];
    end

    sample_d       = sample_q;
    sample_valid_d = sample_valid_q;
    overrun_d      = overrun_q;
    if (done_q) begin
      // a new sample always wins; it is only an overrun if the old one was
      // not being taken in this very cycle
      sample_d       = sat_sample;
      sample_valid_d = 1'b1;
      if (sample_valid_q && !i_SampleReady) begin
        overrun_d = 1'b1;
      end
    end else if (sample_valid_q && i_SampleReady) begin
      sample_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      wb_valid_q     <= 1'b0;
      wb_id_q        <= '0;
      wb_value_q     <= '0;
      s1_valid_q     <= 1'b0;
      s1_id_q        <= '0;
      s1_term_q      <= '0;
      acc_q          <= '0;
      armed_q        <= 1'b0;
      done_q         <= 1'b0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      wb_valid_q     <= wb_valid_d;
      wb_id_q        <= wb_id_d;
      wb_value_q     <= wb_value_d;
      s1_valid_q     <= s1_valid_d;
      s1_id_q        <= s1_id_d;
      s1_term_q      <= s1_term_d;
      acc_q          <= acc_d;
      armed_q        <= armed_d;
      done_q         <= done_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      overrun_q      <= overrun_d;
    end
  end

  assign o_OperatorWritebackValid = wb_valid_q;
  assign o_OperatorWritebackID    = wb_id_q;
  assign o_OperatorWritebackValue = wb_value_q;
  assign o_Sample                 = sample_q;
  assign o_SampleValid            = sample_valid_q;
  assign o_SampleOverrun          = overrun_q;

endmodule
